// File: rtl/read_align_pkg.sv
// Shared definitions for the read-alignment pipe: access-type encodings,
// the decoded access descriptor and small width/size helpers.
package read_align_pkg;

  localparam logic [2:0] CONF_LB  = 3'b000;  // signed byte
  localparam logic [2:0] CONF_LH  = 3'b001;  // signed half
  localparam logic [2:0] CONF_LW  = 3'b010;  // signed word
  localparam logic [2:0] CONF_LD  = 3'b011;  // double (64-bit words only)
  localparam logic [2:0] CONF_LBU = 3'b100;  // unsigned byte
  localparam logic [2:0] CONF_LHU = 3'b101;  // unsigned half
  localparam logic [2:0] CONF_LWU = 3'b110;  // unsigned word

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef struct packed {
    size_e size;
    logic  sgn;
  } conf_dec_t;

  // Byte-offset width for a given word width.
  function automatic int addr_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Width needed to hold a count from 0 to depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Offset bits that must be zero for a size-aligned access.
  function automatic int size_mask(input size_e s);
    case (s)
      SZ_B:    return 0;
      SZ_H:    return 1;
      SZ_W:    return 3;
      default: return 7;
    endcase
  endfunction

  // Reserved 111 falls through to the signed-word default; a double on a
  // 32-bit word collapses to a signed word.
  function automatic conf_dec_t decode_conf(input logic [2:0] conf, input logic has_d);
    conf_dec_t d;
    d.size = SZ_W;
    d.sgn  = 1'b1;
    case (conf)
      CONF_LB:  d.size = SZ_B;
      CONF_LH:  d.size = SZ_H;
      CONF_LW:  d.size = SZ_W;
      CONF_LD:  if (has_d) d.size = SZ_D;
      CONF_LBU: begin d.size = SZ_B; d.sgn = 1'b0; end
      CONF_LHU: begin d.size = SZ_H; d.sgn = 1'b0; end
      CONF_LWU: begin d.size = SZ_W; d.sgn = 1'b0; end
      default:  d.size = SZ_W;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/read_align_fifo.sv
// Small synchronous FIFO used for both the request metadata queue and the
// aligned response queue. Read data is the registered head entry, so it is
// stable for as long as the entry is not popped. Pushes into a full FIFO
// and pops from an empty FIFO are dropped.
module read_align_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Qualify requests against the current fill level.
  always_comb begin
    empty   = (count == '0);
    do_push = push && (count != CW'(DEPTH));
    do_pop  = pop && !empty;
    rdata   = mem[rptr];
  end

  // Storage, pointers and fill count; storage clears so outputs read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= ptr_next(wptr);
      end
      if (do_pop) rptr <= ptr_next(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/read_align_pipe.sv
// Read-alignment pipe: queues {conf, offset} per accepted read, aligns the
// SRAM word when it returns, and buffers the result for the consumer.
// A credit counter bounds outstanding plus buffered reads to DEPTH, so
// neither queue can overflow.
// Optional build macro READ_ALIGN_MISALIGN_ERR_EN adds resp_err, flagging
// offsets that are not aligned to the access size.
module read_align_pipe
  import read_align_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [addr_w(DATA_W)-1:0] req_addr,
  input  logic [2:0]                req_conf,
  input  logic                      sram_rvalid,
  input  logic [DATA_W-1:0]         sram_rdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
`ifdef READ_ALIGN_MISALIGN_ERR_EN
  output logic                      resp_err,
`endif
  output logic [DATA_W-1:0]         resp_data
);

  localparam int AW = addr_w(DATA_W);
  localparam int MW = 3 + AW;
  localparam int CW = cnt_w(DEPTH);
`ifdef READ_ALIGN_MISALIGN_ERR_EN
  localparam int RW = DATA_W + 1;
`else
  localparam int RW = DATA_W;
`endif

  logic [CW-1:0]     credits;
  logic              ready_en;
  logic              accept;
  logic              resp_pop;

  logic              meta_empty;
  logic              meta_pop;
  logic [MW-1:0]     meta_rdata;
  logic [2:0]        meta_conf;
  logic [AW-1:0]     meta_off;

  logic              resp_empty;
  logic [RW-1:0]     resp_wdata;
  logic [RW-1:0]     resp_rdata;

  conf_dec_t         dec;
  logic [AW-1:0]     off_mask;
  logic [AW-1:0]     lane_off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              msb;
  logic [DATA_W-1:0] aligned;
`ifdef READ_ALIGN_MISALIGN_ERR_EN
  logic              misalign;
`endif

  // Handshakes; a pop in the same cycle frees the credit an accept needs.
  always_comb begin
    resp_valid = !resp_empty;
    resp_pop   = resp_valid && resp_ready;
    req_ready  = ready_en && ((credits != '0) || resp_pop);
    accept     = req_valid && req_ready;
    meta_pop   = sram_rvalid && !meta_empty;
    meta_conf  = meta_rdata[MW-1:AW];
    meta_off   = meta_rdata[AW-1:0];
  end

  // Hold req_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Credits track DEPTH minus entries held in both queues; only accept and
  // response pop change the total, so a metadata-to-response move is neutral.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CW'(DEPTH);
    end else begin
      case ({accept, resp_pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
    end
  end

  read_align_fifo #(
    .WIDTH (MW),
    .DEPTH (DEPTH)
  ) u_meta_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .wdata ({req_conf, req_addr}),
    .pop   (meta_pop),
    .rdata (meta_rdata),
    .empty (meta_empty)
  );

  // Align the returning word using the oldest request's conf and offset.
  always_comb begin
    dec      = decode_conf(meta_conf, DATA_W == 64);
    off_mask = AW'(size_mask(dec.size));
    lane_off = meta_off & ~off_mask;
    shifted  = sram_rdata >> {lane_off, 3'b000};
    keep     = '1;
    msb      = 1'b0;
    case (dec.size)
      SZ_B: begin
        keep = DATA_W'(64'h0000_0000_0000_00FF);
        msb  = shifted[7];
      end
      SZ_H: begin
        keep = DATA_W'(64'h0000_0000_0000_FFFF);
        msb  = shifted[15];
      end
      SZ_W: begin
        keep = DATA_W'(64'h0000_0000_FFFF_FFFF);
        msb  = shifted[31];
      end
      default: begin
        keep = '1;
        msb  = 1'b0;
      end
    endcase
    aligned = (shifted & keep) | ((dec.sgn && msb) ? ~keep : '0);
  end

`ifdef READ_ALIGN_MISALIGN_ERR_EN
  // Misalignment is reported alongside the aligned-down data.
  always_comb begin
    misalign   = |(meta_off & off_mask);
    resp_wdata = {misalign, aligned};
  end
`else
  // Response entry carries only the aligned data.
  always_comb begin
    resp_wdata = aligned;
  end
`endif

  read_align_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (meta_pop),
    .wdata (resp_wdata),
    .pop   (resp_pop),
    .rdata (resp_rdata),
    .empty (resp_empty)
  );

  // Response outputs come straight from the registered queue head.
  always_comb begin
    resp_data = resp_rdata[DATA_W-1:0];
`ifdef READ_ALIGN_MISALIGN_ERR_EN
    resp_err  = resp_rdata[DATA_W];
`endif
  end

endmodule

// File: tb/tb_read_align_pipe.sv
// Bench for read_align_pipe: a 32-bit/DEPTH=2 and a 64-bit/DEPTH=3 instance,
// directed scenarios followed by random traffic, scoreboard-checked.
module tb_read_align_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        req_valid   [2];
  logic [2:0]  req_addr    [2];
  logic [2:0]  req_conf    [2];
  logic        sram_rvalid [2];
  logic [63:0] sram_rdata  [2];
  logic        resp_ready  [2];

  logic        a_req_ready, a_resp_valid;
  logic [31:0] a_resp_data;
  logic        b_req_ready, b_resp_valid;
  logic [63:0] b_resp_data;
`ifdef READ_ALIGN_MISALIGN_ERR_EN
  logic        a_resp_err, b_resp_err;
`endif

  read_align_pipe #(.DATA_W(32), .DEPTH(2)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid[0]),
    .req_ready   (a_req_ready),
    .req_addr    (req_addr[0][1:0]),
    .req_conf    (req_conf[0]),
    .sram_rvalid (sram_rvalid[0]),
    .sram_rdata  (sram_rdata[0][31:0]),
    .resp_valid  (a_resp_valid),
    .resp_ready  (resp_ready[0]),
`ifdef READ_ALIGN_MISALIGN_ERR_EN
    .resp_err    (a_resp_err),
`endif
    .resp_data   (a_resp_data)
  );

  read_align_pipe #(.DATA_W(64), .DEPTH(3)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid[1]),
    .req_ready   (b_req_ready),
    .req_addr    (req_addr[1]),
    .req_conf    (req_conf[1]),
    .sram_rvalid (sram_rvalid[1]),
    .sram_rdata  (sram_rdata[1]),
    .resp_valid  (b_resp_valid),
    .resp_ready  (resp_ready[1]),
`ifdef READ_ALIGN_MISALIGN_ERR_EN
    .resp_err    (b_resp_err),
`endif
    .resp_data   (b_resp_data)
  );

  typedef struct packed {
    logic       id;
    logic [2:0] conf;
    logic [2:0] addr;
  } pend_t;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [63:0] data;
  } exp_t;

  pend_t pend[$];
  exp_t  sb[$];
  int    pend_cnt [2];
  int    resp_cnt [2];
  bit    ready_en [2];
  int    checks   = 0;
  int    failures = 0;

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int dw(input int k);
    return (k == 0) ? 32 : 64;
  endfunction

  // Reference: pick the lane by size-aligned byte offset, then extend.
  function automatic logic [64:0] ref_resp(input int w, input logic [63:0] din,
                                           input int addr, input logic [2:0] conf);
    int          size;
    bit          sgn;
    int          off;
    logic [63:0] d, v, keep;
    d = (w == 32) ? (din & 64'h0000_0000_FFFF_FFFF) : din;
    case (conf)
      3'd0:    begin size = 1; sgn = 1; end
      3'd1:    begin size = 2; sgn = 1; end
      3'd2:    begin size = 4; sgn = 1; end
      3'd3:    begin size = (w == 64) ? 8 : 4; sgn = 1; end
      3'd4:    begin size = 1; sgn = 0; end
      3'd5:    begin size = 2; sgn = 0; end
      3'd6:    begin size = 4; sgn = 0; end
      default: begin size = 4; sgn = 1; end
    endcase
    off  = addr - (addr % size);
    keep = (size == 8) ? '1 : ((64'd1 << (size * 8)) - 64'd1);
    v    = (d >> (off * 8)) & keep;
    if (sgn && v[size*8-1]) v = v | ~keep;
    if (w == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {((addr % size) != 0), v};
  endfunction

  function automatic bit exp_ready(input int k);
    return ready_en[k] && (((dep(k) - pend_cnt[k] - resp_cnt[k]) > 0) ||
                           (resp_cnt[k] > 0 && resp_ready[k]));
  endfunction

  // Transaction-level model, advanced on each active edge.
  initial begin
    logic [64:0] r;
    exp_t        e;
    pend_t       p;
    bit          acc, pop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        sb.delete();
        for (int k = 0; k < 2; k++) begin
          pend_cnt[k] = 0;
          resp_cnt[k] = 0;
          ready_en[k] = 0;
        end
      end else begin
        for (int k = 0; k < 2; k++) begin
          acc = req_valid[k] && exp_ready(k);
          pop = resp_ready[k] && (resp_cnt[k] > 0);
          if (sram_rvalid[k] && pend_cnt[k] > 0) begin
            for (int i = 0; i < pend.size(); i++) begin
              if (pend[i].id == k[0]) begin
                r      = ref_resp(dw(k), sram_rdata[k], int'(pend[i].addr), pend[i].conf);
                e.id   = k[0];
                e.err  = r[64];
                e.data = r[63:0];
                sb.push_back(e);
                pend.delete(i);
                break;
              end
            end
            pend_cnt[k]--;
            resp_cnt[k]++;
          end
          if (acc) begin
            p.id   = k[0];
            p.conf = req_conf[k];
            p.addr = (k == 0) ? (req_addr[k] & 3'd3) : req_addr[k];
            pend.push_back(p);
            pend_cnt[k]++;
          end
          if (pop) resp_cnt[k]--;
          ready_en[k] = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the model and scoreboard.
  initial begin
    logic        rv, rdy, er;
    logic [63:0] rd;
    int          idx;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rv  = (k == 0) ? a_resp_valid : b_resp_valid;
        rdy = (k == 0) ? a_req_ready  : b_req_ready;
        rd  = (k == 0) ? {32'h0, a_resp_data} : b_resp_data;
`ifdef READ_ALIGN_MISALIGN_ERR_EN
        er  = (k == 0) ? a_resp_err : b_resp_err;
`else
        er  = 1'b0;
`endif
        if (!rst_n) begin
          chk("rst_resp_valid", k, {63'h0, rv}, 64'h0);
          chk("rst_req_ready", k, {63'h0, rdy}, 64'h0);
          chk("rst_resp_data", k, rd, 64'h0);
        end else begin
          chk("req_ready", k, {63'h0, rdy}, {63'h0, exp_ready(k)});
          chk("resp_valid", k, {63'h0, rv}, {63'h0, (resp_cnt[k] > 0)});
          if (rv) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
              if (sb[i].id == k[0]) begin
                idx = i;
                break;
              end
            end
            if (idx < 0) begin
              chk("unexpected_resp", k, rd, 64'hx);
            end else begin
              chk("resp_data", k, rd, sb[idx].data);
`ifdef READ_ALIGN_MISALIGN_ERR_EN
              chk("resp_err", k, {63'h0, er}, {63'h0, sb[idx].err});
`endif
              if (resp_ready[k]) sb.delete(idx);
            end
          end
        end
      end
    end
  end

  task automatic set_in(input int k, input bit rv, input int addr, input int conf,
                        input bit srv, input logic [63:0] sd, input bit rr);
    req_valid[k]   = rv;
    req_addr[k]    = 3'(addr);
    req_conf[k]    = 3'(conf);
    sram_rvalid[k] = srv;
    sram_rdata[k]  = sd;
    resp_ready[k]  = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 0, 0, 0, 64'h0, 1);
    set_in(1, 0, 0, 0, 0, 64'h0, 1);
    repeat (n) tick();
  endtask

  task automatic one_read(input int k, input int addr, input int conf, input logic [63:0] d);
    set_in(k, 1, addr, conf, 0, 64'h0, 1);
    tick();
    set_in(k, 0, 0, 0, 1, d, 1);
    tick();
    set_in(k, 0, 0, 0, 0, 64'h0, 1);
    tick();
  endtask

  initial begin
    int t_conf [12] = '{0, 4, 1, 5, 2, 6, 3, 7, 1, 1, 5, 0};
    int t_addr [12] = '{3, 3, 3, 3, 3, 3, 1, 2, 1, 2, 0, 0};
    int b_conf [6]  = '{2, 3, 0, 5, 6, 1};
    int b_addr [6]  = '{4, 4, 4, 6, 5, 3};

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 64'h0, 1);
    set_in(1, 0, 0, 0, 0, 64'h0, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) one_read(0, t_addr[i], t_conf[i], 64'hF1F2_F3F4);
    for (int i = 0; i < 6; i++)  one_read(1, b_addr[i], b_conf[i], 64'h0123_4567_89AB_CDEF);

    // Backpressure with responses held, then pop and accept together.
    set_in(0, 1, 0, 2, 0, 64'h0, 0);
    tick();
    tick();
    set_in(0, 1, 1, 0, 1, 64'h0000_0000_1111_2281, 0);
    tick();
    set_in(0, 1, 2, 5, 1, 64'h0000_0000_3344_5566, 0);
    tick();
    tick();
    set_in(0, 1, 1, 4, 0, 64'h0, 1);
    tick();
    set_in(0, 0, 0, 0, 1, 64'h0000_0000_A0B0_C0D0, 1);
    tick();
    idle(3);

    // Back-to-back issue, each word returning one cycle after its request.
    set_in(0, 1, 1, 0, 0, 64'h0, 1);
    tick();
    set_in(0, 1, 2, 4, 1, 64'h0000_0000_0000_8000, 1);
    tick();
    set_in(0, 1, 0, 2, 1, 64'h0000_0000_0099_0000, 1);
    tick();
    set_in(0, 0, 0, 0, 1, 64'h0000_0000_DEAD_BEEF, 1);
    tick();
    idle(3);

    // Reset with two reads in flight; late data must be dropped.
    set_in(0, 1, 0, 2, 0, 64'h0, 0);
    set_in(1, 1, 0, 3, 0, 64'h0, 0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 64'h0, 0);
    set_in(1, 0, 0, 0, 0, 64'h0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 1, 64'h0000_0000_1234_5678, 1);
    set_in(1, 0, 0, 0, 1, 64'h1234_5678_9ABC_DEF0, 1);
    tick();
    tick();
    idle(2);
    set_in(0, 1, 0, 0, 0, 64'h0, 0);
    repeat (3) tick();
    idle(4);

    // Random traffic with occasional resets.
    repeat (4000) begin
      for (int k = 0; k < 2; k++) begin
        set_in(k, ($urandom % 10) < 6, $urandom_range(0, (k == 0) ? 3 : 7),
               $urandom % 8, $urandom % 2, {$urandom, $urandom}, ($urandom % 10) < 7);
      end
      if ($urandom % 700 == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    idle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
